// File: rtl/denormalize_shifter.sv
// Sequential right-shift denormalizer for the divider datapath: undoes the leading-zero
// normalization one bit per clock and reports a sticky bit for rounding/exactness.
module denormalize_shifter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic               sticky
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [SHIFT_W-1:0] cnt_q;
  logic               arith_q;
  logic               acc_q;
  logic [WIDTH-1:0]   data_out_q;
  logic               sticky_q;
  logic               done_q;
  logic               busy_q;

  // Fill bit uses the current MSB so a negative operand stays negative at every step.
  logic fill;
  assign fill = arith_q & shreg_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      arith_q    <= 1'b0;
      acc_q      <= 1'b0;
      data_out_q <= '0;
      sticky_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q <= data_in;
            cnt_q   <= shift_amt;
            arith_q <= arith;
            acc_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (cnt_q != '0) begin
            shreg_q <= {fill, shreg_q[WIDTH-1:1]};
            acc_q   <= acc_q | shreg_q[0];
            cnt_q   <= cnt_q - SHIFT_W'(1);
          end else begin
            data_out_q <= shreg_q;
            sticky_q   <= acc_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign sticky   = sticky_q;

endmodule

// File: tb/tb_denormalize_shifter.sv
// Randomized self-checking bench for denormalize_shifter against an arithmetic reference model.
module tb_denormalize_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] shift_amt;
  logic       arith;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic       sticky;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_out;
  logic       last_sticky;

  always #5 clk = ~clk;

  denormalize_shifter #(.WIDTH(8), .SHIFT_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .shift_amt(shift_amt),
    .arith    (arith),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .sticky   (sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: plain arithmetic shift, sticky = any nonzero bit among the n discarded LSBs.
  function automatic logic [7:0] ref_data(input logic [7:0] d, input int n, input logic a);
    if (a) return 8'($signed(d) >>> n);
    return d >> n;
  endfunction

  function automatic logic ref_sticky(input logic [7:0] d, input int n);
    return (n == 0) ? 1'b0 : ((d % (1 << n)) != 0);
  endfunction

  // Starts at a negedge with DUT idle; returns at the negedge where done is high.
  // With glitch set, start is held high with junk operands while the op is running.
  task automatic do_op(input logic [7:0] d, input int n, input logic a, input bit glitch);
    int e;
    data_in = d; shift_amt = 3'(n); arith = a; start = 1'b1;
    tick();
    e = 0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    while (!done && e < 20) begin
      check("out_stable", data_out, last_out);
      check("sticky_stable", sticky, last_sticky);
      if (glitch) begin
        start = 1'b1; data_in = 8'($urandom); shift_amt = 3'($urandom); arith = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      e++;
    end
    start = 1'b0;
    check("latency", e, n + 1);
    check("data_out", data_out, ref_data(d, n, a));
    check("sticky", sticky, ref_sticky(d, n));
    check("busy_at_done", busy, 0);
    last_out    = ref_data(d, n, a);
    last_sticky = ref_sticky(d, n);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      tick();
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_out", data_out, last_out);
      check("idle_sticky", sticky, last_sticky);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data_in = '0; shift_amt = '0; arith = 1'b0;
    last_out = '0; last_sticky = 1'b0;
    @(negedge clk);
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", data_out, 0);
    check("rst_sticky", sticky, 0);
    rst_n = 1'b1;
    idle(1);

    // Directed cases
    do_op(8'b1011_0000, 3, 1'b0, 1'b0);
    check("t1_val", data_out, 8'b0001_0110);
    idle(1);
    do_op(8'b1011_0101, 2, 1'b1, 1'b0);
    check("t2_val", data_out, 8'b1110_1101);
    check("t2_sticky", sticky, 1);
    idle(1);
    do_op(8'h5A, 0, 1'b0, 1'b0);
    idle(1);
    do_op(8'h80, 7, 1'b0, 1'b0);
    check("t3_val", data_out, 8'h01);
    idle(2);
    do_op(8'hF0, 4, 1'b0, 1'b1);
    check("t4_val", data_out, 8'h0F);
    idle(2);

    // Reset mid-operation
    data_in = 8'hFF; shift_amt = 3'd5; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out", data_out, 0);
    check("mid_rst_sticky", sticky, 0);
    rst_n = 1'b1;
    last_out = '0; last_sticky = 1'b0;
    idle(8);
    do_op(8'hA5, 3, 1'b1, 1'b0);
    idle(1);

    // Back-to-back: second start issued in the done cycle
    do_op(8'h81, 1, 1'b0, 1'b0);
    check("t6a_val", data_out, 8'h40);
    do_op(8'h81, 1, 1'b1, 1'b0);
    check("t6b_val", data_out, 8'hC0);
    check("t6b_sticky", sticky, 1);
    idle(1);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      do_op(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), bit'($urandom_range(0, 3) == 0));
      idle(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/denormalize_shifter.md
Name: denormalize_shifter

Overview:
- Sequential right-shift denormalizer on the divider datapath.
- It undoes the left-normalization driven by the leading-zero count: it takes a normalized operand, typically the remainder, plus the stored shift amount, and shifts it back right one bit per clock.
- Start/done handshake to the divider control FSM; also reports a sticky bit (OR of all bits shifted out) for rounding/exactness checks.

Parameters:
- WIDTH, 8, data width in bits.
- SHIFT_W, 3, shift-amount width; maximum shift = 2^SHIFT_W - 1, which must be ≤ WIDTH - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- data_in  input  WIDTH  normalized operand; captured on an accepted start.
- shift_amt  input  SHIFT_W  right-shift distance; captured on an accepted start.
- arith  input  1  1 = sign-extend (replicate MSB), 0 = zero-fill; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- data_out  output  WIDTH  denormalized result; held until the next completion.
- sticky  output  1  OR of all bits shifted out during the last operation; held with data_out.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE.
  - busy, done, sticky, data_out, internal shift register and counter all = 0.
  - Reset has priority over all other inputs.
  - Reset mid-operation aborts with no done pulse; the partial result is discarded.
- States: IDLE, SHIFT.
- IDLE:
  - done is 0, except in the single cycle after completion.
  - On an edge with start=1 (call it E0):
    - load data_in into the shift register;
    - cnt = shift_amt;
    - latch arith;
    - clear the sticky accumulator;
    - state → SHIFT, busy = 1.
  - start=0: remain in IDLE; outputs hold.
- SHIFT, on each edge:
  - If cnt ≠ 0:
    - shift register >> 1, with MSB fill = latched arith ? current MSB : 0;
    - sticky accumulator |= bit shifted out of the LSB;
    - cnt = cnt - 1.
  - If cnt = 0:
    - data_out = shift register;
    - sticky = accumulator;
    - done = 1 for exactly one cycle;
    - busy = 0;
    - state → IDLE.
- Latency for shift N:
  - done is high in the cycle following edge E(N+1), i.e. N+1 edges after the start edge.
  - N=0 gives done one edge after the start edge, with data_out = data_in.
- start while in SHIFT (busy=1): ignored, not queued; the captured operands are unaffected by data_in/shift_amt/arith changes.
- Back-to-back: start asserted in the done cycle is accepted at the next edge (state is IDLE). In that cycle done falls and busy rises.
- data_out and sticky change only at completion (or reset); they are stable at all other times.
- Arithmetic fill uses the current MSB at each step, so a negative operand stays negative for any N.
- No overflow is possible; counter width is SHIFT_W and never wraps (it stops at 0).

Test Plan:
1. data_in=8'b1011_0000, shift_amt=3, arith=0, start pulse → busy high for 4 cycles; done on the 4th edge after start; data_out=8'b0001_0110; sticky=0.
2. data_in=8'b1011_0101, shift_amt=2, arith=1 → done after 3 edges; data_out=8'b1110_1101; sticky=1.
3. data_in=8'h5A, shift_amt=0 → done 1 edge after start; data_out=8'h5A; sticky=0. Then shift_amt=7, arith=0, data_in=8'h80 → data_out=8'h01, sticky=0, done after 8 edges.
4. Start 8'hF0/shift 4; at edge 2 assert start with 8'h0F/shift 1 → second request ignored; data_out=8'h0F, sticky=0, single done pulse at edge 5.
5. Start 8'hFF/shift 5; drive rst_n=0 at edge 3 → busy=0, done never pulses, data_out=0, sticky=0; a new start after reset release behaves normally.
6. Back-to-back: assert start in the done cycle of op 1 (8'h81, shift 1, arith 0 → 8'h40, sticky=1) with op 2 (8'h81, shift 1, arith 1 → 8'hC0, sticky=1) → op 2 accepted immediately, done pulses 2 edges later, no idle gap.
